// File: rtl/return_address_stack_pkg.sv
// Shared configuration and type packages for the return address stack.
//   cva5_config : cpu_config_t and the default CONFIG (provides the RAS depth)
//   cva5_types  : ras_snapshot_t {ptr,cnt} used by the speculative snapshot queue
// Snapshot fields are sized for stacks up to 256 entries; the stack truncates
// them to its own pointer/count width.
package cva5_config;
  typedef struct packed {
    int unsigned RAS_DEPTH;
  } cpu_config_t;

  localparam cpu_config_t CONFIG = '{RAS_DEPTH: 8};
endpackage

package cva5_types;
  localparam int RAS_SNAP_PTR_W = 8;
  localparam int RAS_SNAP_CNT_W = 9;

  typedef struct packed {
    logic [RAS_SNAP_PTR_W-1:0] ptr;
    logic [RAS_SNAP_CNT_W-1:0] cnt;
  } ras_snapshot_t;
endpackage

// File: rtl/return_address_stack_lutram.sv
// lutram_1w_1r: distributed RAM, one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk          : clock
//   waddr/raddr  : write / read index
//   we           : write enable
//   new_ram_data : write data
//   ram_data_out : read data (combinational from raddr)
module lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         new_ram_data,
  output logic [WIDTH-1:0]         ram_data_out
);
  logic [WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk)
    if (we) ram[waddr] <= new_ram_data;

  assign ram_data_out = ram[raddr];
endmodule

// File: rtl/return_address_stack.sv
// Return address stack with speculative {ptr,cnt} snapshots.
//   clk, rst           : clock, synchronous active-low reset
//   push / new_addr    : call fetched, push return address
//   pop                : return fetched, pop top
//   branch_fetched     : take a snapshot of {ptr,cnt} (pre-update value)
//   branch_retired     : drop oldest snapshot
//   early_branch_flush : restore {ptr,cnt} from oldest snapshot, empty queue
//   addr / valid       : top of stack (0 when empty) / stack non-empty
//   spec_full          : snapshot queue full (registered)
// Stack contents are never rolled back; a flush only restores ptr/cnt.
module return_address_stack
  import cva5_config::*;
  import cva5_types::*;
#(
  parameter int RAS_DEPTH  = CONFIG.RAS_DEPTH,
  parameter int SPEC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        early_branch_flush,
  output logic [31:0] addr,
  output logic        valid,
  output logic        spec_full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int SW = $clog2(SPEC_DEPTH);

  logic [PW-1:0]  ptr;
  logic [CW-1:0]  cnt;
  logic [31:0]    ram_rd;

  ras_snapshot_t  snap_q [SPEC_DEPTH];
  logic [SW-1:0]  head, tail;
  logic [SW:0]    scnt, scnt_nxt;

  logic           both, do_push, do_pop, we, enq, deq;
  logic [PW-1:0]  waddr;

  // Push+pop on a non-empty stack replaces the top in place.
  assign both    = push & pop & (cnt != '0);
  assign do_push = push & ~both;
  assign do_pop  = pop & ~push & (cnt != '0);
  assign we      = rst & ~early_branch_flush & push;
  assign waddr   = both ? ptr : ptr + PW'(1);

  // A retire frees a slot in the same cycle, so fetch+retire succeeds when full.
  assign deq = branch_retired & (scnt != '0);
  assign enq = branch_fetched & (~spec_full | deq);

  always_comb begin
    scnt_nxt = scnt;
    case ({enq, deq})
      2'b10:   scnt_nxt = scnt + 1'b1;
      2'b01:   scnt_nxt = scnt - 1'b1;
      default: scnt_nxt = scnt;
    endcase
  end

  lutram_1w_1r #(.WIDTH(32), .DEPTH(RAS_DEPTH)) stack_ram (
    .clk          (clk),
    .waddr        (waddr),
    .raddr        (ptr),
    .we           (we),
    .new_ram_data (new_addr),
    .ram_data_out (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      cnt       <= '0;
      head      <= '0;
      tail      <= '0;
      scnt      <= '0;
      spec_full <= 1'b0;
    end else if (early_branch_flush) begin
      if (scnt != '0) begin
        ptr <= snap_q[head].ptr[PW-1:0];
        cnt <= snap_q[head].cnt[CW-1:0];
      end
      head      <= '0;
      tail      <= '0;
      scnt      <= '0;
      spec_full <= 1'b0;
    end else begin
      if (do_push) begin
        ptr <= ptr + PW'(1);
        cnt <= (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + CW'(1);
      end else if (do_pop) begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - CW'(1);
      end
      if (enq) begin
        snap_q[tail] <= '{ptr: RAS_SNAP_PTR_W'(ptr), cnt: RAS_SNAP_CNT_W'(cnt)};
        tail         <= tail + SW'(1);
      end
      if (deq) head <= head + SW'(1);
      scnt      <= scnt_nxt;
      spec_full <= (scnt_nxt == (SW+1)'(SPEC_DEPTH));
    end
  end

  assign valid = (cnt != '0);
  assign addr  = valid ? ram_rd : 32'h0;
endmodule
